avg_frame_tx: RTL

- Downstream consumer of the sample averager: captures each window average (the o_cnt_flag/o_average pulse, one per SAMPLING_RATE input samples) into a small FIFO.
- Serializes each average as a 4-byte frame on a byte-wide valid/ready stream for the host link or UART bridge.
- Absorbs host-side backpressure and flags dropped averages.

---
 rtl/avg_frame_tx.sv | 139 +++++++++++++
 1 files changed

// File: rtl/avg_frame_tx.sv
// Buffers window averages from the sample averager in a small FIFO and sends each
// one as a 4-byte frame (header, then three data bytes MSB first) on a valid/ready byte stream.
module avg_frame_tx #(
   parameter int          DATA_OUT_WIDTH = 21,
   parameter int          FIFO_DEPTH     = 8,
   parameter logic [7:0]  HDR_BYTE       = 8'hA5
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            i_avg_valid,
   input  logic [DATA_OUT_WIDTH-1:0]       i_average,
   output logic [7:0]                      o_tx_data,
   output logic                            o_tx_valid,
   input  logic                            i_tx_ready,
   output logic [$clog2(FIFO_DEPTH):0]     o_fifo_count,
   output logic                            o_overflow,
   output logic                            o_busy
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_B2,
      ST_B1,
      ST_B0
   } state_t;

   state_t                    state, next_state;
   logic [DATA_OUT_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]             wr_ptr, rd_ptr;
   logic [CW-1:0]             fifo_count;
   logic [23:0]               frame_reg;
   logic [23:0]               head_ext;
   logic [7:0]                tx_data, next_data;
   logic                      tx_valid, next_valid;
   logic                      overflow;
   logic                      pop, push, handshake;

   assign handshake = tx_valid && i_tx_ready;
   // A pop in the same cycle frees a slot, so a full FIFO still accepts the write.
   assign push = i_avg_valid && ((fifo_count < DEPTH_C) || pop);

   always_comb begin
      head_ext                     = '0;
      head_ext[DATA_OUT_WIDTH-1:0] = mem[rd_ptr];
   end

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      next_state = state;
      next_data  = tx_data;
      next_valid = tx_valid;
      pop        = 1'b0;
      case (state)
         ST_IDLE: begin
            next_valid = 1'b0;
            if (fifo_count != '0) begin
               pop        = 1'b1;
               next_state = ST_HDR;
               next_valid = 1'b1;
               next_data  = HDR_BYTE;
            end
         end
         ST_HDR: if (handshake) begin
            next_state = ST_B2;
            next_data  = frame_reg[23:16];
         end
         ST_B2: if (handshake) begin
            next_state = ST_B1;
            next_data  = frame_reg[15:8];
         end
         ST_B1: if (handshake) begin
            next_state = ST_B0;
            next_data  = frame_reg[7:0];
         end
         ST_B0: if (handshake) begin
            if (fifo_count != '0) begin
               pop        = 1'b1;
               next_state = ST_HDR;
               next_data  = HDR_BYTE;
            end else begin
               next_state = ST_IDLE;
               next_valid = 1'b0;
            end
         end
         default: begin
            next_state = ST_IDLE;
            next_valid = 1'b0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         tx_data    <= '0;
         tx_valid   <= 1'b0;
         frame_reg  <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
      end else begin
         state    <= next_state;
         tx_data  <= next_data;
         tx_valid <= next_valid;
         if (pop) begin
            frame_reg <= head_ext;
            rd_ptr    <= rd_ptr + AW'(1);
         end
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (push && !pop)
            fifo_count <= fifo_count + CW'(1);
         else if (pop && !push)
            fifo_count <= fifo_count - CW'(1);
         if (i_avg_valid && !push)
            overflow <= 1'b1;
      end
   end

   // NOTE: the storage array has no reset; pointers and count define which entries are valid.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= i_average;
   end

   assign o_tx_data    = tx_data;
   assign o_tx_valid   = tx_valid;
   assign o_fifo_count = fifo_count;
   assign o_overflow   = overflow;
   assign o_busy       = (state != ST_IDLE);

endmodule
